// File: rtl/edm_pulse_ctrl.sv
// EDM discharge-pulse sequencer: drives the MOSFET gate through WAIT_BREAK / DISCHARGE / OFF
// using a microsecond timebase, detects breakdown, short and open gap, and packs a status word.
module edm_pulse_ctrl #(
  parameter int unsigned TICK_DIV        = 100,
  parameter logic [15:0] V_BREAK_MV      = 16'd1500,
  parameter logic [15:0] V_SHORT_MV      = 16'd300,
  parameter logic [15:0] OPEN_TIMEOUT_US = 16'd1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        machine_start,
  input  logic        machine_stop,
  input  logic [15:0] Ton_data,
  input  logic [15:0] Toff_data,
  input  logic [15:0] gap_volt,
  output logic        gate_out,
  output logic        running,
  output logic [15:0] feedback_data
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_BREAK = 2'd1,
    DISCHARGE  = 2'd2,
    OFF        = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   us_q, us_d;
  logic [15:0]   ton_q, ton_d, toff_q, toff_d;
  logic          short_q, short_d, open_q, open_d;
  logic [7:0]    dcnt_q, dcnt_d;
  logic          gate_q, gate_d, run_q, run_d;
  logic [15:0]   fb_q, fb_d;
  logic          tick, entry;

  assign tick  = (presc_q == PRESC_MAX);
  assign entry = (state_d != state_q);

  always_comb begin
    state_d = state_q;
    short_d = short_q;
    open_d  = open_q;
    dcnt_d  = dcnt_q;
    if (machine_stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (machine_start) begin
            state_d = WAIT_BREAK;
            short_d = 1'b0;
            open_d  = 1'b0;
            dcnt_d  = 8'd0;
          end
        end
        WAIT_BREAK: begin
          // Breakdown is checked every cycle and beats a coincident timeout.
          if (gap_volt < V_BREAK_MV) begin
            state_d = DISCHARGE;
          end else if (tick && (us_q == OPEN_TIMEOUT_US - 16'd1)) begin
            state_d = OFF;
            open_d  = 1'b1;
          end
        end
        DISCHARGE: begin
          if (tick && (us_q == 16'd0) && (gap_volt < V_SHORT_MV)) begin
            state_d = OFF;
            short_d = 1'b1;
          end else if (tick && (us_q == ton_q - 16'd1)) begin
            state_d = OFF;
            dcnt_d  = dcnt_q + 8'd1;
          end
        end
        OFF: begin
          if (tick && (us_q == toff_q - 16'd1)) begin
            state_d = WAIT_BREAK;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Timebase restarts on every state entry so each dwell is a whole number of ticks.
  always_comb begin
    presc_d = presc_q + PW'(1);
    us_d    = us_q;
    if (entry) begin
      presc_d = '0;
      us_d    = 16'd0;
    end else if (tick) begin
      presc_d = '0;
      us_d    = us_q + 16'd1;
    end
  end

  always_comb begin
    ton_d  = ton_q;
    toff_d = toff_q;
    if (entry && (state_d == WAIT_BREAK)) begin
      ton_d  = (Ton_data  == 16'd0) ? 16'd1 : Ton_data;
      toff_d = (Toff_data == 16'd0) ? 16'd1 : Toff_data;
    end
  end

  assign gate_d = (state_d == WAIT_BREAK) || (state_d == DISCHARGE);
  assign run_d  = (state_d != IDLE);
  assign fb_d   = {state_d, run_d, short_d, open_d, 3'b000, dcnt_d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      us_q    <= 16'd0;
      ton_q   <= 16'd0;
      toff_q  <= 16'd0;
      short_q <= 1'b0;
      open_q  <= 1'b0;
      dcnt_q  <= 8'd0;
      gate_q  <= 1'b0;
      run_q   <= 1'b0;
      fb_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      us_q    <= us_d;
      ton_q   <= ton_d;
      toff_q  <= toff_d;
      short_q <= short_d;
      open_q  <= open_d;
      dcnt_q  <= dcnt_d;
      gate_q  <= gate_d;
      run_q   <= run_d;
      fb_q    <= fb_d;
    end
  end

  assign gate_out      = gate_q;
  assign running       = run_q;
  assign feedback_data = fb_q;

endmodule

// File: tb/tb_edm_pulse_ctrl.sv
// Bench for edm_pulse_ctrl: cycle-count reference model compared every cycle, plus
// hand-computed status words at key points (shortened timebase: 4 clk per us, 20 us timeout).
module tb_edm_pulse_ctrl;

  localparam int TD      = 4;
  localparam int OPEN_US = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] ton = 16'd5;
  logic [15:0] toff = 16'd3;
  logic [15:0] gap = 16'd5000;
  logic        gate_out, running;
  logic [15:0] feedback_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  edm_pulse_ctrl #(
    .TICK_DIV(TD),
    .V_BREAK_MV(16'd1500),
    .V_SHORT_MV(16'd300),
    .OPEN_TIMEOUT_US(16'(OPEN_US))
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .machine_start(start),
    .machine_stop(stop),
    .Ton_data(ton),
    .Toff_data(toff),
    .gap_volt(gap),
    .gate_out(gate_out),
    .running(running),
    .feedback_data(feedback_data)
  );

  // Reference model: tracks phase and cycles spent in it; dwell limits are whole-us * TD.
  logic [1:0] m_state = 2'd0, mn_state;
  int         m_el = 0, mn_el;
  int         m_ton = 0, mn_ton, m_toff = 0, mn_toff;
  logic       m_short = 1'b0, mn_short, m_open = 1'b0, mn_open;
  logic [7:0] m_cnt = 8'd0, mn_cnt;

  always_comb begin
    mn_state = m_state;
    mn_short = m_short;
    mn_open  = m_open;
    mn_cnt   = m_cnt;
    mn_ton   = m_ton;
    mn_toff  = m_toff;
    if (stop) begin
      mn_state = 2'd0;
    end else begin
      case (m_state)
        2'd0: if (start) begin
          mn_state = 2'd1; mn_short = 1'b0; mn_open = 1'b0; mn_cnt = 8'd0;
        end
        2'd1: begin
          if (gap < 16'd1500) mn_state = 2'd2;
          else if (m_el + 1 == OPEN_US * TD) begin mn_state = 2'd3; mn_open = 1'b1; end
        end
        2'd2: begin
          if (m_el + 1 == TD && gap < 16'd300) begin mn_state = 2'd3; mn_short = 1'b1; end
          else if (m_el + 1 == m_ton * TD) begin mn_state = 2'd3; mn_cnt = m_cnt + 8'd1; end
        end
        default: if (m_el + 1 == m_toff * TD) mn_state = 2'd1;
      endcase
    end
    if (mn_state == 2'd1 && m_state != 2'd1) begin
      mn_ton  = (ton == 16'd0) ? 1 : int'(ton);
      mn_toff = (toff == 16'd0) ? 1 : int'(toff);
    end
    mn_el = (mn_state != m_state) ? 0 : m_el + 1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 2'd0; m_el <= 0; m_ton <= 0; m_toff <= 0;
      m_short <= 1'b0; m_open <= 1'b0; m_cnt <= 8'd0;
    end else begin
      m_state <= mn_state; m_el <= mn_el; m_ton <= mn_ton; m_toff <= mn_toff;
      m_short <= mn_short; m_open <= mn_open; m_cnt <= mn_cnt;
    end
  end

  logic        exp_gate, exp_run;
  logic [15:0] exp_fb;
  assign exp_gate = (m_state == 2'd1) || (m_state == 2'd2);
  assign exp_run  = (m_state != 2'd0);
  assign exp_fb   = {m_state, exp_run, m_short, m_open, 3'b000, m_cnt};

  always @(negedge clk) begin
    checks++;
    if ({gate_out, running, feedback_data} !== {exp_gate, exp_run, exp_fb}) begin
      failures++;
      $display("FAIL model_cmp t=%0t got gate=%b run=%b fb=%h want gate=%b run=%b fb=%h",
               $time, gate_out, running, feedback_data, exp_gate, exp_run, exp_fb);
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1; cyc(1); stop = 1'b0;
  endtask

  initial begin
    cyc(3);
    chk("reset_fb", feedback_data, 16'h0000);
    chk("reset_gate", {15'd0, gate_out}, 16'd0);
    rst_n = 1'b1;
    cyc(2);

    // Normal pulse: Ton=5us, Toff=3us, immediate breakdown
    ton = 16'd5; toff = 16'd3; gap = 16'd1000;
    do_start();
    chk("t1_wait", feedback_data, 16'h6000);
    chk("t1_gate_on", {15'd0, gate_out}, 16'd1);
    cyc(1);  chk("t1_dis_start", feedback_data, 16'hA000);
    cyc(19); chk("t1_dis_end", feedback_data, 16'hA000);
    cyc(1);  chk("t1_off", feedback_data, 16'hE001);
    chk("t1_gate_off", {15'd0, gate_out}, 16'd0);
    cyc(11); chk("t1_off_end", feedback_data, 16'hE001);
    cyc(1);  chk("t1_rewait", feedback_data, 16'h6001);
    do_stop();
    chk("t1_stop", feedback_data, 16'h0001);

    // Open gap: no breakdown for 20us
    gap = 16'd5000;
    do_start();
    chk("t2_wait", feedback_data, 16'h6000);
    cyc(79); chk("t2_wait_end", feedback_data, 16'h6000);
    cyc(1);  chk("t2_open", feedback_data, 16'hE800);
    do_stop();
    chk("t2_sticky", feedback_data, 16'h0800);

    // Short at first discharge tick
    ton = 16'd5; gap = 16'd100;
    do_start();
    chk("t3_flags_clr", feedback_data, 16'h6000);
    cyc(1); chk("t3_dis", feedback_data, 16'hA000);
    cyc(3); chk("t3_dis_end", feedback_data, 16'hA000);
    cyc(1); chk("t3_short", feedback_data, 16'hF000);
    do_stop();
    chk("t3_sticky", feedback_data, 16'h1000);

    // Stop mid-discharge; start while running is ignored
    gap = 16'd1000;
    do_start();
    chk("t4_flags_clr", feedback_data, 16'h6000);
    cyc(1);
    do_start();
    chk("t4_start_ignored", feedback_data, 16'hA000);
    cyc(4);
    do_stop();
    chk("t4_stop_fb", feedback_data, 16'h0000);
    chk("t4_stop_gate", {15'd0, gate_out}, 16'd0);

    // Zero settings treated as 1us
    ton = 16'd0; toff = 16'd0;
    do_start();
    chk("t5_wait", feedback_data, 16'h6000);
    cyc(1); chk("t5_dis", feedback_data, 16'hA000);
    cyc(3); chk("t5_dis_end", feedback_data, 16'hA000);
    cyc(1); chk("t5_off", feedback_data, 16'hE001);
    cyc(3); chk("t5_off_end", feedback_data, 16'hE001);
    cyc(1); chk("t5_rewait", feedback_data, 16'h6001);
    do_stop();
    chk("t5_stop", feedback_data, 16'h0001);
    start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
    chk("t5_start_stop", feedback_data, 16'h0001);

    // Async reset mid-OFF
    ton = 16'd1; toff = 16'd1;
    do_start();
    cyc(5); chk("t6_off", feedback_data, 16'hE001);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_fb", feedback_data, 16'h0000);
    chk("t6_async_out", {14'd0, gate_out, running}, 16'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

    // 256 pulses of 9 cycles each: discharge_cnt wraps to 0
    do_start();
    cyc(2291); chk("t6_cnt255", feedback_data, 16'hE0FF);
    cyc(9);    chk("t6_cnt_wrap", feedback_data, 16'hE000);
    do_stop();
    cyc(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/edm_pulse_ctrl.md
Name: edm_pulse_ctrl

Overview:
Discharge-pulse sequencer for the EDM power stage. It takes the start/stop commands and the Ton/Toff settings decoded by the SPI command slave, drives the power-MOSFET gate, and uses the gap voltage from the ADC to detect breakdown, short circuit and open gap. It returns a packed status word that the top level routes onto the SPI feedback_data path.

Parameters:
TICK_DIV, 100, clk cycles per 1 us timing tick (100 MHz sys_clk).
V_BREAK_MV, 16'd1500, gap voltage below which breakdown is declared (mV).
V_SHORT_MV, 16'd300, gap voltage below which the gap is declared short at the first discharge tick (mV).
OPEN_TIMEOUT_US, 16'd1000, maximum wait for breakdown before an open-gap abort (us).

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
machine_start  in  1  one-cycle start pulse
machine_stop  in  1  one-cycle stop pulse
Ton_data  in  16  discharge on-time (us)
Toff_data  in  16  off-time between pulses (us)
gap_volt  in  16  gap voltage (mV), already synchronised to clk by the top level
gate_out  out  1  MOSFET gate drive, 1 = on
running  out  1  1 whenever state != IDLE
feedback_data  out  16  status word

Behaviour:
- Reset (async, active-low):
  - state = IDLE, gate_out = 0, running = 0, feedback_data = 0.
  - All counters and flags = 0.
- States (2-bit encoding):
  - IDLE = 0, WAIT_BREAK = 1, DISCHARGE = 2, OFF = 3.
- Timebase:
  - The prescaler counts 0..TICK_DIV-1 and asserts a tick when it reaches TICK_DIV-1.
  - us_cnt increments on each tick.
  - The prescaler and us_cnt both clear on every state entry, so each state dwell is an exact multiple of TICK_DIV cycles.
- Registered outputs:
  - gate_out and running are decoded from the next state and registered, so they change on the same edge as the state.
- Setting latch:
  - ton_r and toff_r are latched from Ton_data/Toff_data on every entry to WAIT_BREAK.
  - A value of 0 is forced to 1.
  - Changing the settings mid-pulse has no effect until the next cycle.
- IDLE (gate 0):
  - machine_start with machine_stop low -> WAIT_BREAK.
  - On this transition, short_flag, open_flag and discharge_cnt clear.
- WAIT_BREAK (gate 1):
  - gap_volt < V_BREAK_MV -> DISCHARGE, evaluated every cycle, not only on ticks.
  - Otherwise, on the tick where us_cnt reaches OPEN_TIMEOUT_US-1 -> OFF, with open_flag set.
  - If both conditions hold in the same cycle, breakdown wins.
- DISCHARGE (gate 1):
  - On the first tick (us_cnt == 0), if gap_volt < V_SHORT_MV -> OFF, set short_flag, discharge_cnt not incremented.
  - Otherwise, on the tick where us_cnt reaches ton_r-1 -> OFF, discharge_cnt increments (8-bit, wraps 255 -> 0).
  - If ton_r == 1, the short check takes priority on that tick.
- OFF (gate 0):
  - On the tick where us_cnt reaches toff_r-1 -> WAIT_BREAK.
- machine_stop:
  - From any state -> IDLE on the next edge; gate_out is 0 from that edge.
  - Stop has priority over start and over all other transitions.
  - machine_start while not IDLE is ignored.
- Flags:
  - short_flag and open_flag are sticky until the next accepted start.
- feedback_data, registered each cycle:
  - [15:14] = state, [13] = running, [12] = short_flag, [11] = open_flag, [10:8] = 0, [7:0] = discharge_cnt.

Test Plan:
1. Start with Ton=5, Toff=3, gap_volt=1000 -> gate high 1 cycle after start, DISCHARGE for 500 cycles, gate low for 300 cycles, then WAIT_BREAK again; discharge_cnt = 1 after the first pulse.
2. gap_volt held at 5000 after start -> gate high for exactly 100000 cycles, then OFF; open_flag = 1, discharge_cnt = 0, feedback_data[11] = 1.
3. gap_volt = 100 on entering DISCHARGE -> OFF after 100 cycles; short_flag = 1, discharge_cnt unchanged.
4. machine_stop mid-DISCHARGE -> gate_out = 0 and feedback_data[15:13] = 0 on the next edge; a later start clears the flags and discharge_cnt.
5. Ton=0, Toff=0 -> both treated as 1: 100-cycle discharge, 100-cycle off. Also assert start and stop together in IDLE -> stays IDLE.
6. Assert rst_n low mid-OFF -> all outputs are 0 immediately (asynchronously). Also run 256 pulses -> discharge_cnt wraps to 0.
